// File: rtl/sigdel_decim.sv
`default_nettype none
// ============================================================================
//  Module   : sigdel_decim
//  Purpose  : Sigma-delta bitstream decimator. A second-order CIC (sinc2)
//             filter with decimation ratio 2^DEC_LOG2 turns a 1-bit density
//             stream back into an OUT_W-bit parallel sample.
//  Ports    : clk        - clock, all logic on the rising edge
//             rst        - synchronous active-high reset, clears all state
//             din        - bitstream sample (1 = +full-scale, 0 = zero)
//             din_valid  - din is accepted only when this is high
//             dout       - decimated sample, held between updates
//             dout_valid - one-cycle pulse when dout carries a new sample
//             sat        - one-cycle pulse with dout_valid when dout clipped
//  Params   : OUT_W      - output width, must satisfy 2*DEC_LOG2 >= OUT_W
//             DEC_LOG2   - log2 of the decimation ratio N
//  Revision : 1.0 - initial release
// ============================================================================
module sigdel_decim #(
   parameter int OUT_W    = 8,
   parameter int DEC_LOG2 = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             din_valid,
   output logic [OUT_W-1:0] dout,
   output logic             dout_valid,
   output logic             sat
);

   // Internal width: the sinc2 gain is N^2 = 2^(2*DEC_LOG2), plus one bit so
   // that full scale (exactly N^2) is representable and can be detected.
   localparam int W      = 2*DEC_LOG2 + 1;
   localparam int MSB    = 2*DEC_LOG2 - 1;
   localparam int LOW_W  = 2*DEC_LOG2 - OUT_W;
   localparam logic [DEC_LOG2-1:0] CNT_LAST = '1;
   localparam logic [1:0]          WARM_DONE = 2'd2;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [W-1:0]        i1_q, i1_d;
   logic [W-1:0]        i2_q, i2_d;
   logic [DEC_LOG2-1:0] cnt_q, cnt_d;
   logic                tick_q, tick_d;
   logic [W-1:0]        snap_q, snap_d;
   logic [W-1:0]        i2_dly_q, i2_dly_d;
   logic [W-1:0]        c1_dly_q, c1_dly_d;
   logic [1:0]          warm_q, warm_d;
   logic [OUT_W-1:0]    dout_q, dout_d;
   logic                dout_valid_q, dout_valid_d;
   logic                sat_q, sat_d;

   logic [W-1:0]        din_ext_w;
   logic [W-1:0]        c1_w;
   logic [W-1:0]        c2_w;
   logic                clip_w;

   assign din_ext_w = {{(W-1){1'b0}}, din};

   // Both comb stages are evaluated in the cycle after the tick so that the
   // sample is registered and flagged exactly two cycles after the tick.
   assign c1_w   = snap_q - i2_dly_q;
   assign c2_w   = c1_w - c1_dly_q;
   // c2 never exceeds N^2, so the top bit alone marks the one clipped value.
   assign clip_w = c2_w[W-1];

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      i1_d         = i1_q;
      i2_d         = i2_q;
      cnt_d        = cnt_q;
      tick_d       = 1'b0;
      snap_d       = snap_q;
      i2_dly_d     = i2_dly_q;
      c1_dly_d     = c1_dly_q;
      warm_d       = warm_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      sat_d        = 1'b0;

      // Integrators: i2 accumulates the already-updated i1. Wrap is intended.
      if (din_valid) begin
         i1_d  = i1_q + din_ext_w;
         i2_d  = i2_q + i1_d;
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CNT_LAST) begin
            tick_d = 1'b1;
            snap_d = i2_d;
         end
      end

      // Comb stages and output mapping, once per window.
      if (tick_q) begin
         i2_dly_d = snap_q;
         c1_dly_d = c1_w;
         if (clip_w) begin
            dout_d = '1;
         end else begin
            dout_d = c2_w[MSB -: OUT_W];
         end
         // The first two windows carry comb start-up transients; dout is
         // still updated but not advertised.
         if (warm_q == WARM_DONE) begin
            dout_valid_d = 1'b1;
            sat_d        = clip_w;
         end else begin
            warm_d = warm_q + 2'd1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         i1_q         <= '0;
         i2_q         <= '0;
         cnt_q        <= '0;
         tick_q       <= 1'b0;
         snap_q       <= '0;
         i2_dly_q     <= '0;
         c1_dly_q     <= '0;
         warm_q       <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         sat_q        <= 1'b0;
      end else begin
         i1_q         <= i1_d;
         i2_q         <= i2_d;
         cnt_q        <= cnt_d;
         tick_q       <= tick_d;
         snap_q       <= snap_d;
         i2_dly_q     <= i2_dly_d;
         c1_dly_q     <= c1_dly_d;
         warm_q       <= warm_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         sat_q        <= sat_d;
      end
   end

   // Fraction bits below the output LSB are truncated by design.
   generate
      if (LOW_W > 0) begin : g_low_bits
         logic unused_low_w;
         assign unused_low_w = ^c2_w[LOW_W-1:0];
      end
   endgenerate

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign sat        = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_sigdel_decim.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sigdel_decim
//  Purpose  : Self-checking bench for sigdel_decim. A direct triangular-FIR
//             model of the sinc2 response predicts every output sample and
//             its arrival cycle; expectations are queued as stimulus is
//             applied and popped when dout_valid pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sigdel_decim;

   localparam int OUT_W    = 8;
   localparam int DEC_LOG2 = 8;
   localparam int N        = 1 << DEC_LOG2;

   logic             clk = 1'b0;
   logic             rst;
   logic             din;
   logic             din_valid;
   logic [OUT_W-1:0] dout;
   logic             dout_valid;
   logic             sat;

   sigdel_decim #(.OUT_W(OUT_W), .DEC_LOG2(DEC_LOG2)) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .din_valid  (din_valid),
      .dout       (dout),
      .dout_valid (dout_valid),
      .sat        (sat)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int               cyc;
      logic [OUT_W-1:0] dout;
      logic             sat;
   } exp_t;

   exp_t exp_q[$];
   bit   hist[$];
   int   acc;
   int   ticks;
   int   n_cmp   = 0;
   int   n_err   = 0;
   int   n_valid = 0;

   // ---------------------------------------------------------------------
   // Driver + model: one clock cycle of stimulus. The sinc2 response to a
   // tick is sum over the last 2N samples weighted 1..N, N-1..0.
   // ---------------------------------------------------------------------
   task automatic step(input logic d, input logic v, input logic r);
      int   c2;
      int   w;
      exp_t e;
      rst       = r;
      din       = d;
      din_valid = v;
      if (r) begin
         hist.delete();
         acc   = 0;
         ticks = 0;
         exp_q.delete();
      end else if (v) begin
         hist.push_back(d);
         if (hist.size() > 2*N) void'(hist.pop_front());
         acc++;
         if (acc % N == 0) begin
            ticks++;
            if (ticks >= 3) begin
               c2 = 0;
               for (int k = 0; k < 2*N; k++) begin
                  if (k < hist.size()) begin
                     w = (k < N) ? (k + 1) : (2*N - 1 - k);
                     c2 += int'(hist[hist.size()-1-k]) * w;
                  end
               end
               e.cyc  = cyc + 2;
               e.sat  = (c2 >= N*N);
               e.dout = e.sat ? {OUT_W{1'b1}} : OUT_W'(c2 >> (2*DEC_LOG2 - OUT_W));
               exp_q.push_back(e);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------------
   // Monitor: pops the scoreboard whenever the DUT flags a sample.
   // ---------------------------------------------------------------------
   always @(negedge clk) begin
      exp_t e;
      if (dout_valid === 1'b1) begin
         n_valid++;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_valid: dout_valid=1 dout=%0d at cycle %0d, required no pulse",
                     dout, cyc);
         end else begin
            e = exp_q.pop_front();
            if (dout !== e.dout || sat !== e.sat || cyc != e.cyc) begin
               n_err++;
               $display("FAIL sample: got dout=%0d sat=%0b cycle=%0d, required dout=%0d sat=%0b cycle=%0d",
                        dout, sat, cyc, e.dout, e.sat, e.cyc);
            end
         end
      end else if (dout_valid !== 1'b0 || sat !== 1'b0) begin
         n_cmp++;
         n_err++;
         $display("FAIL idle_flags: got dout_valid=%b sat=%b at cycle %0d, required 0 0",
                  dout_valid, sat, cyc);
      end
   end

   // ---------------------------------------------------------------------
   // Tests
   // ---------------------------------------------------------------------
   task automatic test_reset();
      // rst must win over din_valid
      repeat (3) step(1'b1, 1'b1, 1'b1);
      n_cmp++;
      if (dout !== '0 || dout_valid !== 1'b0 || sat !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state: got dout=%0d valid=%b sat=%b, required 0 0 0",
                  dout, dout_valid, sat);
      end
   endtask

   task automatic test_dc_zero();
      int v0;
      step(1'b0, 1'b0, 1'b1);
      v0 = n_valid;
      for (int i = 0; i < 4*N; i++) step(1'b0, 1'b1, 1'b0);
      repeat (4) step(1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (n_valid - v0 != 2 || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL zero_count: got %0d outputs (%0d pending), required 2 (0 pending)",
                  n_valid - v0, exp_q.size());
      end
      n_cmp++;
      if (dout !== 8'd0) begin
         n_err++;
         $display("FAIL zero_value: got dout=%0d, required 0", dout);
      end
   endtask

   task automatic test_density(input int period, input int ones, input int want,
                               input int windows);
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < windows*N; i++) step(((i % period) < ones), 1'b1, 1'b0);
      repeat (4) step(1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (dout !== want[OUT_W-1:0] || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL density_%0d_of_%0d: got dout=%0d (%0d pending), required %0d (0 pending)",
                  ones, period, dout, exp_q.size(), want);
      end
   endtask

   task automatic test_full_scale_then_zero();
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5*N; i++) step(1'b1, 1'b1, 1'b0);
      repeat (4) step(1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (dout !== 8'hFF) begin
         n_err++;
         $display("FAIL full_scale: got dout=%0d, required 255", dout);
      end
      for (int i = 0; i < 2*N; i++) step(1'b0, 1'b1, 1'b0);
      repeat (4) step(1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (dout !== 8'd0 || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL ones_to_zero: got dout=%0d (%0d pending), required 0 (0 pending)",
                  dout, exp_q.size());
      end
   endtask

   task automatic test_gapped();
      logic ph;
      int   v0;
      step(1'b0, 1'b0, 1'b1);
      v0 = n_valid;
      ph = 1'b1;
      for (int i = 0; i < 4*N; i++) begin
         step(ph, 1'b1, 1'b0);
         ph = ~ph;
         step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
         step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
      repeat (4) step(1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (n_valid - v0 != 2 || dout !== 8'd128) begin
         n_err++;
         $display("FAIL gapped: got %0d outputs dout=%0d, required 2 outputs dout=128",
                  n_valid - v0, dout);
      end
   endtask

   task automatic test_reset_cancel();
      int v0;
      step(1'b0, 1'b0, 1'b1);
      v0 = n_valid;
      for (int i = 0; i < 3*N; i++) step(i[0], 1'b1, 1'b0);
      // cycle T+1 of the third tick: the pending sample must never appear
      step(1'b0, 1'b0, 1'b1);
      repeat (4) step(1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (n_valid != v0 || dout !== 8'd0) begin
         n_err++;
         $display("FAIL cancel_pending: got %0d outputs dout=%0d, required 0 outputs dout=0",
                  n_valid - v0, dout);
      end
   endtask

   task automatic test_reset_mid_window();
      int v0;
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4*N + 99; i++) step(i[0], 1'b1, 1'b0);
      n_cmp++;
      if (dout !== 8'd128) begin
         n_err++;
         $display("FAIL pre_reset_value: got dout=%0d, required 128", dout);
      end
      step(1'b1, 1'b1, 1'b1);
      n_cmp++;
      if (dout !== '0 || dout_valid !== 1'b0 || sat !== 1'b0) begin
         n_err++;
         $display("FAIL mid_reset_state: got dout=%0d valid=%b sat=%b, required 0 0 0",
                  dout, dout_valid, sat);
      end
      v0 = n_valid;
      for (int i = 0; i < 3*N; i++) step(((i % 4) == 0), 1'b1, 1'b0);
      repeat (4) step(1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (n_valid - v0 != 1 || dout !== 8'd64) begin
         n_err++;
         $display("FAIL restart: got %0d outputs dout=%0d, required 1 output dout=64",
                  n_valid - v0, dout);
      end
   endtask

   initial begin
      rst       = 1'b1;
      din       = 1'b0;
      din_valid = 1'b0;
      acc       = 0;
      ticks     = 0;
      @(posedge clk);
      #1;
      test_reset();
      test_dc_zero();
      test_density(2, 1, 128, 5);
      test_density(4, 1, 64, 5);
      test_density(4, 3, 192, 5);
      test_full_scale_then_zero();
      test_gapped();
      test_reset_cancel();
      test_reset_mid_window();
      repeat (4) step(1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d samples outstanding, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
